// File: rtl/axi_pattern_master.sv
// AXI4 burst traffic master: writes a seeded counting pattern, reads it back and checks it.
module axi_pattern_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_BURST_LEN  = 16,
    parameter int unsigned C_NUM_BURSTS       = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 32'h4000_0000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     SEED,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [15:0]                       ERR_COUNT,
    output logic                              BUSY,
    output logic                              M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic                              M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic                              M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW          = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW          = C_M_AXI_DATA_WIDTH;
    localparam int unsigned BYTES       = DW / 8;
    localparam int unsigned BURST_BYTES = C_M_AXI_BURST_LEN * BYTES;
    localparam int unsigned SIZE        = $clog2(BYTES);
    localparam int unsigned LW          = $clog2(C_M_AXI_BURST_LEN) + 1;
    localparam int unsigned BW          = $clog2(C_NUM_BURSTS) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            init_q1, init_q2;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   seed_q, seed_d;
    logic [DW-1:0]   pat_q, pat_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            wlast_q, wlast_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            busy_q, busy_d;
    logic            err_ev;

    logic            start_c;
    logic [1:0]      mode_eff_c;
    logic            last_beat_c;
    logic            last_burst_c;
    logic            rd_bad_c;

    assign start_c      = init_q1 & ~init_q2;
    assign mode_eff_c   = (MODE == 2'b00) ? 2'b11 : MODE;
    assign last_beat_c  = (beat_q == LW'(C_M_AXI_BURST_LEN - 1));
    assign last_burst_c = (burst_q == BW'(C_NUM_BURSTS - 1));
    // One read beat is one error event however many of its conditions fail
    assign rd_bad_c     = ((mode_q == 2'b11) && (M_AXI_RDATA != pat_q)) ||
                          (M_AXI_RRESP != 2'b00) ||
                          (M_AXI_RLAST != last_beat_c);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        pat_d     = pat_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = done_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        err_ev    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_c) begin
                    mode_d    = mode_eff_c;
                    seed_d    = SEED;
                    pat_d     = SEED;
                    addr_d    = C_TARGET_BASE_ADDR;
                    beat_d    = '0;
                    burst_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                    if (mode_eff_c[0]) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR: begin
                if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (C_M_AXI_BURST_LEN == 1);
                    state_d   = S_WDATA;
                end
            end
            S_WDATA: begin
                if (M_AXI_WREADY) begin
                    pat_d = pat_q + DW'(1);
                    if (last_beat_c) begin
                        beat_d   = '0;
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = S_WRESP;
                    end else begin
                        beat_d  = beat_q + LW'(1);
                        wlast_d = (beat_q == LW'(C_M_AXI_BURST_LEN - 2));
                    end
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    err_ev   = (M_AXI_BRESP != 2'b00);
                    if (last_burst_c) begin
                        burst_d = '0;
                        if (mode_q[1]) begin
                            state_d   = S_RADDR;
                            arvalid_d = 1'b1;
                            addr_d    = C_TARGET_BASE_ADDR;
                            pat_d     = seed_q;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        burst_d   = burst_q + BW'(1);
                        addr_d    = addr_q + AW'(BURST_BYTES);
                        awvalid_d = 1'b1;
                        state_d   = S_WADDR;
                    end
                end
            end
            S_RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    err_ev = rd_bad_c;
                    pat_d  = pat_q + DW'(1);
                    if (last_beat_c) begin
                        beat_d   = '0;
                        rready_d = 1'b0;
                        if (last_burst_c) begin
                            burst_d = '0;
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            burst_d   = burst_q + BW'(1);
                            addr_d    = addr_q + AW'(BURST_BYTES);
                            arvalid_d = 1'b1;
                            state_d   = S_RADDR;
                        end
                    end else begin
                        beat_d = beat_q + LW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_ev) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            init_q1   <= 1'b0;
            init_q2   <= 1'b0;
            mode_q    <= 2'b00;
            seed_q    <= '0;
            pat_q     <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q1   <= INIT_AXI_TXN;
            init_q2   <= init_q1;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            pat_q     <= pat_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_COUNT     = err_cnt_q;
    assign BUSY          = busy_q;

    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = 1'b0;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA   = pat_q;
    assign M_AXI_WSTRB   = {BYTES{1'b1}};
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'(SIZE);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi_pattern_master.md
# axi_pattern_master

Parametrised AXI4 burst traffic master for the block-design test harnesses, generalising the single-shot dummy master. A rising edge on `INIT_AXI_TXN` starts the run. The block then issues `C_NUM_BURSTS` INCR write bursts of a seeded counting pattern, followed by the same number of read bursts. Read data is checked against the pattern, and the result is reported on `TXN_DONE`, `ERROR` and a saturating mismatch counter. Data width, burst length, burst count and operating mode (write-only, read-only, write+check) are all selectable, so one block covers stimulus, readback and soak use inside the slave-VIP bench.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, address width.
- `C_M_AXI_DATA_WIDTH`, 32, data width; legal values 32, 64, 128.
- `C_M_AXI_BURST_LEN`, 16, beats per burst; legal range 1..256.
- `C_NUM_BURSTS`, 4, bursts per phase; legal range 1..1024.
- `C_TARGET_BASE_ADDR`, 32'h4000_0000, first burst address. Must be aligned to `C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8`, and that product must be ≤4096, so no burst crosses a 4 KB boundary.
- `M_AXI_ACLK`  in  1  single clock; all logic is on the rising edge.
- `M_AXI_ARESETN`  in  1  reset, asynchronous, active-low.
- `INIT_AXI_TXN`  in  1  start request; the run starts on a detected rising edge.
- `MODE`  in  2  sampled at start: 01 write-only, 10 read-only, 11 write then read+check. 00 is treated as 11.
- `SEED`  in  `C_M_AXI_DATA_WIDTH`  pattern seed, sampled at start.
- `TXN_DONE`  out  1  level; high from run completion until the next start.
- `ERROR`  out  1  sticky error flag; cleared at the next start.
- `ERR_COUNT`  out  16  count of mismatching beats and error responses; saturates at 16'hFFFF; cleared at start.
- `BUSY`  out  1  high in any state other than IDLE and DONE.
- `M_AXI_AW*`  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out; AWREADY in. AWID, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER are tied 0, except AWCACHE = 4'b0011.
- `M_AXI_W*`  WDATA, WSTRB, WLAST, WVALID out; WREADY in.
- `M_AXI_B*`  BRESP, BVALID in; BREADY out.
- `M_AXI_AR*`  AR channel, mirroring AW.
- `M_AXI_R*`  RDATA, RRESP, RLAST, RVALID in; RREADY out.

## Operation
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- Start detect: `INIT_AXI_TXN` is registered. A start is recognised when the current sample is 1 and the previous sample was 0. Starts are recognised only in IDLE or DONE; starts in any other state are ignored.
- On start:
  - Latch `MODE` and `SEED`.
  - Clear `ERROR`, `ERR_COUNT` and `TXN_DONE`.
  - Zero the burst and beat counters.
  - Go to WADDR if `MODE[0]`, else go to RADDR.
- Burst addressing:
  - Burst k address = `C_TARGET_BASE_ADDR` + k·`C_M_AXI_BURST_LEN`·`C_M_AXI_DATA_WIDTH/8`.
  - AxLEN = `C_M_AXI_BURST_LEN`−1; AxSIZE = log2(bytes); AxBURST = INCR.
- Pattern: beat g (global index across all bursts, starting at 0) = `SEED` + g, modulo 2^`C_M_AXI_DATA_WIDTH`. WSTRB is all ones.
- WADDR: AWVALID is held until AWREADY, then go to WDATA.
- WDATA:
  - WVALID stays high for the whole burst; WDATA advances only on a WVALID&WREADY handshake.
  - WLAST is high on the final beat only.
  - After the last beat, go to WRESP.
- WRESP:
  - BREADY = 1. On the BVALID handshake, BRESP ≠ OKAY sets `ERROR` and increments `ERR_COUNT`.
  - If more bursts remain, go to WADDR. Otherwise go to RADDR if `MODE[1]`, else go to DONE. The global beat index resets to 0 before the read phase.
- RADDR/RDATA: mirror the write phase, with RREADY = 1 in RDATA. Each accepted beat is one error event when any of these holds:
  - RDATA ≠ pattern, but only if the latched mode is 11;
  - RRESP ≠ OKAY;
  - RLAST ≠ (beat is the last of its burst).
- Each error event sets `ERROR` and increments `ERR_COUNT` by exactly 1, even if several conditions hold on that beat.
- DONE: `TXN_DONE` = 1, `BUSY` = 0. The block stays in DONE until the next start.
- One burst is outstanding at a time. No write/read overlap.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - State = IDLE.
  - All VALID and READY outputs = 0, WLAST = 0.
  - `TXN_DONE` = 0, `ERROR` = 0, `ERR_COUNT` = 0, `BUSY` = 0.
  - Address and data outputs = 0.
- Reset asserted mid-burst abandons the transfer immediately. No handshake completion is attempted.
- Start latency: if the edge is sampled at clock N, AWVALID (or ARVALID) and `BUSY` are high after clock N+1.
- Every VALID is registered and never drops before its handshake. Payload is stable while VALID is high and READY is low.
- Zero-wait slave, write phase: one burst takes 1 (AW) + L (W) + 1 (B) cycles plus one state cycle. WVALID is asserted in the cycle after the AW handshake.
- `TXN_DONE` rises one cycle after the final B or R handshake.
- `ERR_COUNT` at 16'hFFFF holds its value. `ERROR` still sets.
- The pattern counter wraps modulo 2^width without an error.
- BURST_LEN = 1: WLAST = 1 on every beat, and RLAST is expected on every beat.

## Test plan
- Reset: hold ARESETN low for 100 ns -> all outputs 0; no VALID asserted for 10 cycles after release without INIT.
- Default params, MODE = 11, SEED = 0, zero-wait VIP memory:
  - 4 write bursts at 0x4000_0000, 0x4000_0040, 0x4000_0080, 0x4000_00C0;
  - readback data 0..63;
  - TXN_DONE = 1, ERROR = 0, ERR_COUNT = 0.
- Random READY backpressure (≈30 % low), DATA_WIDTH = 64, BURST_LEN = 256, NUM_BURSTS = 2, SEED = 64'hFFFF_FFFF_FFFF_FFFE -> pattern wraps through 0; payload stays stable while stalled; ERROR = 0.
- MODE = 11, VIP memory corrupts beat 5 of burst 2 and returns SLVERR on one read burst (16 beats) -> ERROR = 1, ERR_COUNT = 17.
- MODE = 01, then MODE = 10 on separate starts -> no AR in the first run and no AW in the second; the second run reports ERR_COUNT = 0 (no data check in read-only mode).
- Pulse INIT while BUSY; assert ARESETN low mid-WDATA and then release -> the pulse is ignored (burst count unchanged); after reset the block is in IDLE and a clean start completes normally.
